if_id_queue: RTL and testbench

- Instruction queue between the fetch stage and the decode stage.
- Buffers fetched {pc, instr, take} triples in a small circular FIFO.
- Decouples fetch from decode stalls: load-use stalls hold decode while fetch keeps filling the queue.
- Drops all queued, wrong-path instructions in one cycle when execute redirects the PC.

---
 rtl/if_id_queue_if.sv | 31 +++
 rtl/if_id_queue.sv | 85 ++++++++
 tb/tb_if_id_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue handshake bundle: fetch push side, decode pop side, flush and occupancy.
interface if_id_queue_if #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned INSTR_SIZE = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic [PC_SIZE-1:0]    in_pc;
  logic [INSTR_SIZE-1:0] in_instr;
  logic                  in_take;
  logic                  in_ready;
  logic                  out_valid;
  logic [PC_SIZE-1:0]    out_pc;
  logic [INSTR_SIZE-1:0] out_instr;
  logic                  out_take;
  logic                  out_ready;
  logic                  flush;
  logic [CNT_W-1:0]      count;

  modport master (
    output in_valid, in_pc, in_instr, in_take, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, out_take, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_take, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, out_take, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular FIFO of {pc, instr, take}, single-cycle flush, no bypass.
module if_id_queue #(
  parameter int unsigned           PC_SIZE    = 32,
  parameter int unsigned           INSTR_SIZE = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [INSTR_SIZE-1:0] NOP        = INSTR_SIZE'(32'h00000013)
) (
  input logic           clk,
  input logic           rst_n,
  if_id_queue_if.slave  q
);
  localparam int unsigned       PTR_W = $clog2(DEPTH);
  localparam int unsigned       CNT_W = PTR_W + 1;
  localparam int unsigned       ENT_W = PC_SIZE + INSTR_SIZE + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("if_id_queue: DEPTH must be a power of two and >= 2");
  end

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;

  // Handshake qualifiers; flush suppresses both push and pop.
  always_comb begin
    full  = (count_q == FULL);
    empty = (count_q == '0);
    push  = q.in_valid & ~full & ~q.flush;
    pop   = ~empty & q.out_ready & ~q.flush;
  end

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are not reset, occupancy alone marks validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {q.in_pc, q.in_instr, q.in_take};
  end

  // Head entry presented combinationally; an empty queue shows a NOP bubble.
  always_comb begin
    q.in_ready  = ~full;
    q.out_valid = ~empty;
    q.count     = count_q;
    q.out_pc    = '0;
    q.out_instr = NOP;
    q.out_take  = 1'b0;
    if (!empty) begin
      {q.out_pc, q.out_instr, q.out_take} = mem_q[rd_ptr_q];
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, hand-written corner sequences, randomized run against a queue model.
module tb_if_id_queue;
  localparam int unsigned PCW = 32;
  localparam int unsigned IW  = 32;
  localparam int unsigned D   = 4;
  localparam logic [31:0] NOPI = 32'h00000013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_id_queue_if #(.PC_SIZE(PCW), .INSTR_SIZE(IW), .DEPTH(D)) bus ();

  if_id_queue #(.PC_SIZE(PCW), .INSTR_SIZE(IW), .DEPTH(D), .NOP(NOPI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[19:0], 12'h093};
  endfunction

  // Directed vectors: inputs applied for one edge, then expected visible state.
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic v, input logic [31:0] pc, input logic ordy,
                              input logic fl, input logic ev, input logic [31:0] epc,
                              input int ecnt);
    vec_t r;
    r.v = v; r.pc = pc; r.ordy = ordy; r.fl = fl; r.ev = ev; r.epc = epc; r.ecnt = ecnt;
    vecs.push_back(r);
  endfunction

  // Reference model: plain queue of {pc, instr, take}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        take;
  } ent_t;
  ent_t mq[$];

  task automatic model_edge();
    ent_t e;
    bit   was_full;
    if (bus.flush) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == D);
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      if (bus.in_valid && !was_full) begin
        e.pc = bus.in_pc; e.instr = bus.in_instr; e.take = bus.in_take;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model(input string tag);
    ent_t h;
    h = '{pc: 32'h0, instr: NOPI, take: 1'b0};
    if (mq.size() != 0) h = mq[0];
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
    chk({tag, "_ready"}, 64'(bus.in_ready),  64'(mq.size() != D));
    chk({tag, "_count"}, 64'(bus.count),     64'(mq.size()));
    chk({tag, "_pc"},    64'(bus.out_pc),    64'(h.pc));
    chk({tag, "_instr"}, 64'(bus.out_instr), 64'(h.instr));
    chk({tag, "_take"},  64'(bus.out_take),  64'(h.take));
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.in_take = 1'b0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    int sent, got;
    bit tgl, acc;
    idle_inputs();

    // Reset state, both during and after reset.
    #12;
    chk("rst_in_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready),  64'd1);
    chk("rst_in_instr", 64'(bus.out_instr), 64'(NOPI));
    chk("rst_in_count", 64'(bus.count),     64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_ready", 64'(bus.in_ready),  64'd1);
    chk("rst_out_instr", 64'(bus.out_instr), 64'(NOPI));
    chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
    chk("rst_out_count", 64'(bus.count),     64'd0);

    // Single pass-through.
    add(1, 32'h100, 1, 0, 1, 32'h100, 1);
    add(0, 32'h0,   1, 0, 0, 32'h0,   0);
    // Fill under stall, rejected fifth push, drain in order.
    add(1, 32'h0,  0, 0, 1, 32'h0, 1);
    add(1, 32'h4,  0, 0, 1, 32'h0, 2);
    add(1, 32'h8,  0, 0, 1, 32'h0, 3);
    add(1, 32'hC,  0, 0, 1, 32'h0, 4);
    add(1, 32'h10, 0, 0, 1, 32'h0, 4);
    add(0, 32'h0,  1, 0, 1, 32'h4, 3);
    add(0, 32'h0,  1, 0, 1, 32'h8, 2);
    add(0, 32'h0,  1, 0, 1, 32'hC, 1);
    add(0, 32'h0,  1, 0, 0, 32'h0, 0);
    // Full with simultaneous pop: push refused, accepted next cycle.
    add(1, 32'h20, 0, 0, 1, 32'h20, 1);
    add(1, 32'h24, 0, 0, 1, 32'h20, 2);
    add(1, 32'h28, 0, 0, 1, 32'h20, 3);
    add(1, 32'h2C, 0, 0, 1, 32'h20, 4);
    add(1, 32'h30, 1, 0, 1, 32'h24, 3);
    add(1, 32'h30, 0, 0, 1, 32'h24, 4);
    add(0, 32'h0,  1, 0, 1, 32'h28, 3);
    add(0, 32'h0,  1, 0, 1, 32'h2C, 2);
    add(0, 32'h0,  1, 0, 1, 32'h30, 1);
    add(0, 32'h0,  1, 0, 0, 32'h0,  0);
    // Flush with concurrent push and pop; flushed pc 0x40 must never appear.
    add(1, 32'h50, 0, 0, 1, 32'h50, 1);
    add(1, 32'h54, 0, 0, 1, 32'h50, 2);
    add(1, 32'h58, 0, 0, 1, 32'h50, 3);
    add(1, 32'h40, 1, 1, 0, 32'h0,  0);
    add(1, 32'h80, 0, 0, 1, 32'h80, 1);
    add(0, 32'h0,  1, 0, 0, 32'h0,  0);

    foreach (vecs[i]) begin
      bus.in_valid  = vecs[i].v;
      bus.in_pc     = vecs[i].pc;
      bus.in_instr  = instr_of(vecs[i].pc);
      bus.in_take   = vecs[i].pc[2];
      bus.out_ready = vecs[i].ordy;
      bus.flush     = vecs[i].fl;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_count", i), 64'(bus.count),     64'(vecs[i].ecnt));
      chk($sformatf("vec%0d_ready", i), 64'(bus.in_ready),  64'(vecs[i].ecnt != D));
      chk($sformatf("vec%0d_pc", i),    64'(bus.out_pc),    64'(vecs[i].epc));
      chk($sformatf("vec%0d_instr", i), 64'(bus.out_instr),
          64'(vecs[i].ev ? instr_of(vecs[i].epc) : NOPI));
      chk($sformatf("vec%0d_take", i),  64'(bus.out_take),  64'(vecs[i].ev & vecs[i].epc[2]));
    end

    // Wraparound: 10 instructions, out_ready toggling, in_valid held high.
    sent = 0; got = 0; tgl = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      bus.in_valid  = (sent < 10);
      bus.in_pc     = 32'(sent * 4);
      bus.in_instr  = instr_of(32'(sent * 4));
      bus.in_take   = (sent % 3 == 0);
      bus.out_ready = tgl;
      bus.flush     = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("wrap%0d_pc", got),   64'(bus.out_pc),   64'(got * 4));
        chk($sformatf("wrap%0d_take", got), 64'(bus.out_take), 64'(got % 3 == 0));
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      tgl = ~tgl;
    end
    chk("wrap_outputs", 64'(got), 64'd10);
    idle_inputs();
    @(posedge clk); #1;
    chk("wrap_empty", 64'(bus.count), 64'd0);

    // Randomized traffic against the queue model, with a mid-run async reset.
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        check_model("async_rst");
        idle_inputs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_model("post_rst");
      end
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      bus.in_instr  = $urandom;
      bus.in_take   = 1'($urandom);
      bus.out_ready = ((cyc / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 40) == 0);
      model_edge();
      @(posedge clk); #1;
      check_model($sformatf("rnd%0d", cyc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
